adc_cmd_responder: RTL and testbench
====================================

# adc_cmd_responder

Synthesizable stand-in for the MAX10 modular ADC's Avalon-ST command/response endpoint. It accepts conversion commands (valid/channel/ready), waits a fixed conversion latency, and returns one response beat (valid/channel/data/sop/eop) carrying a 12-bit sample. Samples come from a host-writable per-channel register file. The block sits in place of `adc_qsys` in simulation and on bench builds, so the voltage/acceleration path can be driven with scripted values.

## Interface
Parameters:
- `CONV_CYCLES`, 20: cycles spent in CONVERT per command; legal range 1..255.
- `NUM_CH`, 16: channels backed by the register file, numbered 0..NUM_CH-1; fixed at 16.

Ports:
- `Clk` in 1: single clock; all logic is rising-edge.
- `Reset` in 1: synchronous, active-high.
- `command_valid` in 1: command request.
- `command_channel` in 5: requested channel.
- `command_startofpacket`, `command_endofpacket` in 1 each: ignored.
- `command_ready` out 1: command accept enable.
- `response_valid` out 1: response beat present.
- `response_channel` out 5: channel of the completed command.
- `response_data` out 12: sample value.
- `response_startofpacket`, `response_endofpacket` out 1 each: equal to `response_valid`.
- `wr_en` in 1, `wr_ch` in 4, `wr_data` in 12: register-file write port.
- `err_count` out 8: count of invalid-channel commands; saturates at 255.

## Operation
- States:
  - IDLE: `command_ready`=1.
  - CONVERT: `command_ready`=0; the down-counter loads CONV_CYCLES-1.
  - RESPOND: `command_ready`=0.
- Transitions:
  - IDLE→CONVERT on `command_valid & command_ready`; the channel is latched into `ch_q`.
  - CONVERT→RESPOND when the counter equals 0.
  - RESPOND→IDLE unconditionally after 1 cycle.
- Response beat:
  - In RESPOND, `response_valid`=`response_startofpacket`=`response_endofpacket`=1, `response_channel`=`ch_q`.
  - There is no backpressure; the consumer must take the beat in that cycle.
- Data:
  - If `ch_q`<16, data = `regfile[ch_q[3:0]]`, read on the CONVERT→RESPOND edge.
  - If `ch_q`≥16, data = 12'h000 and `err_count` increments once at command acceptance, saturating at 255.
- `response_channel` and `response_data` hold their last values outside RESPOND.
- Register file:
  - Write occurs on the rising edge when `wr_en`=1.
  - A write to the channel being sampled, in the same cycle as the sample, is not seen: the old value is returned.
  - Writes are allowed in any state.
- `command_valid` while `command_ready`=0 is ignored; it is not queued.

## Timing
- A command accepted at edge T produces `response_valid` high during cycle T+CONV_CYCLES+1 only.
- `command_ready` rises in cycle T+CONV_CYCLES+2.
- Minimum command period is CONV_CYCLES+2 cycles; with continuous `command_valid`=1, responses arrive exactly every CONV_CYCLES+2 cycles.
- Reset values:
  - State IDLE, `command_ready`=1.
  - `response_valid`, `response_startofpacket`, `response_endofpacket` = 0.
  - `response_channel`=0, `response_data`=0, `err_count`=0.
  - All regfile entries = 0.
- Reset during CONVERT or RESPOND aborts the command: no response beat is emitted, and `Reset` has priority over a concurrent write.
- `command_ready`=1 in the first cycle after `Reset` deasserts.

## Structure
- Package `adc_emu_pkg` holds:
  - the state enum (IDLE, CONVERT, RESPOND);
  - `ADC_W`=12 and `CH_W`=5;
  - `RF_DEPTH`=16;
  - `ERR_MAX`=8'hFF.
- One sub-module, `adc_emu_regfile`: 16×12 storage, synchronous write, registered read on a sample strobe.
- The top level contains the FSM, counter, channel latch and error counter.

## Test plan
- Reset, write regfile[1]=12'h800, then hold `command_valid`=1 with channel 1 and CONV_CYCLES=20: one beat with channel 1 and data 12'h800 every 22 cycles, with sop/eop/valid high together.
- Command on channel 3, then write regfile[3]=12'h123 during CONVERT (before the sample edge): response data is 12'h123. Repeat with the write on the sample edge itself: the old value is returned.
- Send 300 commands on channel 20: every response is channel 20 with data 12'h000, and `err_count` stops at 255.
- Assert `Reset` 5 cycles after a command is accepted: no `response_valid` is seen, `command_ready`=1 on the first cycle after release, and `err_count`=0.
- Pulse `command_valid` during CONVERT: it is ignored, exactly one response is produced, and the next accept happens only in IDLE.
- Set CONV_CYCLES=1: a command accepted at T gives `response_valid` at T+2 and ready at T+3.

Source files
------------

// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the ADC command/response emulator.
package adc_emu_pkg;

    localparam int         ADC_W    = 12;
    localparam int         CH_W     = 5;
    localparam int         RF_DEPTH = 16;
    localparam int         RF_AW    = $clog2(RF_DEPTH);
    localparam logic [7:0] ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        RESPOND
    } state_t;

endpackage

// File: rtl/adc_emu_regfile.sv
// Host-writable per-channel sample table with a strobed, registered read port.
module adc_emu_regfile
    import adc_emu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [RF_AW-1:0] wr_addr_i,
    input  logic [ADC_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_zero_i,
    input  logic [RF_AW-1:0] rd_addr_i,
    output logic [ADC_W-1:0] rd_data_o
);

    logic [ADC_W-1:0] mem_q [RF_DEPTH];
    logic [ADC_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the table is reset on purpose; scripted runs start from an all-zero sample set.
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
            // NOTE: non-blocking update means a write on the sample edge is not visible to that read.
            if (rd_en_i) begin
                rd_data_q <= rd_zero_i ? '0 : mem_q[rd_addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_cmd_responder.sv
// Avalon-ST ADC command/response stand-in: fixed conversion latency, samples from a register file.
module adc_cmd_responder
    import adc_emu_pkg::*;
#(
    parameter int CONV_CYCLES = 20,
    parameter int NUM_CH      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             command_valid,
    input  logic [CH_W-1:0]  command_channel,
    input  logic             command_startofpacket,
    input  logic             command_endofpacket,
    output logic             command_ready,
    output logic             response_valid,
    output logic [CH_W-1:0]  response_channel,
    output logic [ADC_W-1:0] response_data,
    output logic             response_startofpacket,
    output logic             response_endofpacket,
    input  logic             wr_en,
    input  logic [RF_AW-1:0] wr_ch,
    input  logic [ADC_W-1:0] wr_data,
    output logic [7:0]       err_count
);

    localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [CH_W-1:0] ch_q;
    logic            ready_q;
    logic            valid_q;
    logic [CH_W-1:0] resp_ch_q;
    logic [7:0]      err_q;
    logic [7:0]      err_d;

    logic accept;
    logic sample;
    logic cmd_bad;
    logic ch_bad;
    logic unused_cmd_framing;

    assign accept  = command_valid & ready_q;
    assign sample  = (state_q == CONVERT) && (cnt_q == 8'd0);
    assign cmd_bad = 32'(command_channel) >= 32'(NUM_CH);
    assign ch_bad  = 32'(ch_q) >= 32'(NUM_CH);

    // Packet framing on the command side carries no information for a single-beat command.
    assign unused_cmd_framing = command_startofpacket ^ command_endofpacket;

    always_comb begin
        // NOTE: default first so every path assigns err_d and no latch is inferred.
        err_d = err_q;
        if (accept && cmd_bad && (err_q != ERR_MAX)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            resp_ch_q <= '0;
            err_q     <= '0;
        end else begin
            err_q   <= err_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= CONVERT;
                        cnt_q   <= CNT_LOAD;
                        ch_q    <= command_channel;
                        ready_q <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (cnt_q == 8'd0) begin
                        state_q   <= RESPOND;
                        valid_q   <= 1'b1;
                        resp_ch_q <= ch_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    adc_emu_regfile u_regfile (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ch),
        .wr_data_i (wr_data),
        .rd_en_i   (sample),
        .rd_zero_i (ch_bad),
        .rd_addr_i (ch_q[RF_AW-1:0]),
        .rd_data_o (response_data)
    );

    assign command_ready          = ready_q;
    assign response_valid         = valid_q;
    assign response_startofpacket = valid_q;
    assign response_endofpacket   = valid_q;
    assign response_channel       = resp_ch_q;
    assign err_count              = err_q;

endmodule

// File: tb/tb_adc_cmd_responder.sv
// Directed, table-driven bench for adc_cmd_responder (CONV_CYCLES=20 and a CONV_CYCLES=1 instance).
module tb_adc_cmd_responder;

    localparam int CC = 20;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cv, cv1;
    logic [4:0]  cch, cch1;
    logic        wr_en;
    logic [3:0]  wr_ch;
    logic [11:0] wr_data;

    logic        cr, rv, rsop, reop;
    logic [4:0]  rch;
    logic [11:0] rdat;
    logic [7:0]  err;
    logic        cr1, rv1, rsop1, reop1;
    logic [4:0]  rch1;
    logic [11:0] rdat1;
    logic [7:0]  err1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 Clk = ~Clk;

    adc_cmd_responder #(.CONV_CYCLES(CC), .NUM_CH(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .command_valid(cv), .command_channel(cch),
        .command_startofpacket(1'b0), .command_endofpacket(1'b0),
        .command_ready(cr), .response_valid(rv), .response_channel(rch),
        .response_data(rdat), .response_startofpacket(rsop), .response_endofpacket(reop),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .err_count(err)
    );

    adc_cmd_responder #(.CONV_CYCLES(1), .NUM_CH(16)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .command_valid(cv1), .command_channel(cch1),
        .command_startofpacket(1'b0), .command_endofpacket(1'b0),
        .command_ready(cr1), .response_valid(rv1), .response_channel(rch1),
        .response_data(rdat1), .response_startofpacket(rsop1), .response_endofpacket(reop1),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .err_count(err1)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  wch;
        logic [11:0] wdat;
        logic [4:0]  ch;
        logic [11:0] exp_data;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic rf_write(input logic [3:0] ch, input logic [11:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Presents one command for one cycle; returns at the negedge of the first cycle after acceptance.
    task automatic issue(input string name, input logic [4:0] ch);
        check({name, " ready_before"}, 32'(cr), 1);
        cv = 1'b1; cch = ch;
        tick();
        cv = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [4:0] ch,
                           input logic [11:0] exp_data, input logic [7:0] exp_err);
        int k;
        issue(name, ch);
        k = 1;
        while (!rv && k < CC + 10) begin
            tick();
            k++;
        end
        check({name, " latency"}, 32'(k), CC + 1);
        check({name, " channel"}, 32'(rch), 32'(ch));
        check({name, " data"}, 32'(rdat), 32'(exp_data));
        check({name, " sop_eop"}, 32'({rsop, reop}), 32'b11);
        check({name, " err"}, 32'(err), 32'(exp_err));
        tick();
        check({name, " ready_after"}, 32'({cr, rv}), 32'b10);
    endtask

    initial begin
        int beats, last, k;

        Reset = 1'b1; cv = 1'b0; cch = '0; cv1 = 1'b0; cch1 = '0;
        wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        tick(); tick();
        Reset = 1'b0;

        check("reset ready", 32'(cr), 1);
        check("reset valid_sop_eop", 32'({rv, rsop, reop}), 0);
        check("reset channel", 32'(rch), 0);
        check("reset data", 32'(rdat), 0);
        check("reset err", 32'(err), 0);

        // Continuous command_valid on channel 1: one beat every CC+2 cycles.
        rf_write(4'd1, 12'h800);
        cv = 1'b1; cch = 5'd1;
        beats = 0; last = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (rv) begin
                check("cont channel", 32'(rch), 1);
                check("cont data", 32'(rdat), 32'h800);
                check("cont sop_eop", 32'({rsop, reop}), 32'b11);
                if (beats == 0) check("cont first_beat", 32'(i), CC + 1);
                else            check("cont period", 32'(i - last), CC + 2);
                last = i;
                beats++;
            end
        end
        check("cont beats", 32'(beats), 3);
        cv = 1'b0;
        k = 0;
        while (!cr && k < 60) begin
            tick();
            k++;
        end
        check("cont drain", 32'(cr), 1);

        vecs[0] = '{1'b1, 4'd1,  12'h800, 5'd1,  12'h800, 8'd0};
        vecs[1] = '{1'b1, 4'd0,  12'hABC, 5'd0,  12'hABC, 8'd0};
        vecs[2] = '{1'b1, 4'd15, 12'hFFF, 5'd15, 12'hFFF, 8'd0};
        vecs[3] = '{1'b0, 4'd0,  12'h000, 5'd2,  12'h000, 8'd0};
        vecs[4] = '{1'b0, 4'd0,  12'h000, 5'd16, 12'h000, 8'd1};
        vecs[5] = '{1'b0, 4'd0,  12'h000, 5'd31, 12'h000, 8'd2};
        vecs[6] = '{1'b1, 4'd1,  12'h555, 5'd1,  12'h555, 8'd2};
        vecs[7] = '{1'b0, 4'd0,  12'h000, 5'd0,  12'hABC, 8'd2};
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) rf_write(vecs[v].wch, vecs[v].wdat);
            run_cmd($sformatf("vec%0d", v), vecs[v].ch, vecs[v].exp_data, vecs[v].exp_err);
        end

        // 300 invalid-channel commands: error count saturates at 255.
        Reset = 1'b1; tick(); Reset = 1'b0;
        for (int n = 0; n < 300; n++) begin
            run_cmd("bad_ch", 5'd20, 12'h000, (n + 1 > 255) ? 8'd255 : 8'(n + 1));
        end

        // Reset 5 cycles into CONVERT aborts the command; a concurrent write is dropped.
        issue("abort", 5'd1);
        for (int i = 1; i < 5; i++) tick();
        Reset = 1'b1;
        tick();
        wr_en = 1'b1; wr_ch = 4'd1; wr_data = 12'h777;
        tick();
        Reset = 1'b0; wr_en = 1'b0;
        check("abort ready", 32'(cr), 1);
        check("abort err", 32'(err), 0);
        beats = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rv) beats++;
        end
        check("abort no_beat", 32'(beats), 0);
        run_cmd("abort_rf", 5'd1, 12'h000, 8'd0);

        // A command pulse during CONVERT is ignored.
        rf_write(4'd5, 12'h5A5);
        issue("ignore", 5'd5);
        beats = 0;
        for (int i = 1; i <= 60; i++) begin
            if (rv) begin
                beats++;
                check("ignore channel", 32'(rch), 5);
                check("ignore data", 32'(rdat), 32'h5A5);
            end
            cv = (i == 5);
            if (i == 5) cch = 5'd7;
            tick();
        end
        check("ignore beats", 32'(beats), 1);
        check("ignore err", 32'(err), 0);

        // Write one edge before the sample edge is seen.
        issue("wr_early", 5'd3);
        k = 1;
        while (k < CC - 1) begin tick(); k++; end
        wr_en = 1'b1; wr_ch = 4'd3; wr_data = 12'h123;
        tick(); k++;
        wr_en = 1'b0;
        tick(); k++;
        check("wr_early valid", 32'(rv), 1);
        check("wr_early data", 32'(rdat), 32'h123);
        tick();

        // Write on the sample edge itself returns the old value.
        issue("wr_same", 5'd3);
        k = 1;
        while (k < CC) begin tick(); k++; end
        wr_en = 1'b1; wr_ch = 4'd3; wr_data = 12'h456;
        tick(); k++;
        wr_en = 1'b0;
        check("wr_same valid", 32'(rv), 1);
        check("wr_same data", 32'(rdat), 32'h123);
        tick();
        run_cmd("wr_after", 5'd3, 12'h456, 8'd0);

        // CONV_CYCLES=1: valid at T+2, ready at T+3.
        rf_write(4'd9, 12'h9C9);
        check("cc1 ready_before", 32'(cr1), 1);
        cv1 = 1'b1; cch1 = 5'd9;
        tick();
        cv1 = 1'b0;
        check("cc1 t1", 32'({cr1, rv1}), 32'b00);
        tick();
        check("cc1 t2", 32'({cr1, rv1, rsop1, reop1}), 32'b0111);
        check("cc1 channel", 32'(rch1), 9);
        check("cc1 data", 32'(rdat1), 32'h9C9);
        check("cc1 err", 32'(err1), 0);
        tick();
        check("cc1 t3", 32'({cr1, rv1}), 32'b10);
        check("cc1 hold_data", 32'(rdat1), 32'h9C9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
